// File: rtl/ce_gen_frac.sv
// ce_gen_frac: multi-channel fractional clock-enable generator, ce rate = clk_sys * num / den.
// Ports: clk_sys, reset (async, active-high), pause, resync, cfg_wr/cfg_ch/cfg_num/cfg_den (shadow ratio write),
//        ce[CHANNELS] registered enables, ce_n[CHANNELS] half-phase enables (only with CE_GEN_NEG_EN defined).
module ce_gen_frac #(
  parameter int CHANNELS = 3,
  parameter int ACC_W = 16,
  parameter int RST_NUM = 1,
  parameter int RST_DEN = 8,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                pause,
  input  logic                resync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic [CHANNELS-1:0] ce
`ifdef CE_GEN_NEG_EN
  ,
  output logic [CHANNELS-1:0] ce_n
`endif
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_W-1:0] num, den, snum, sden, acc, num_eff;
    logic [ACC_W:0] sum;
    logic pend, hit, wrap, apply, ce_r;
    // clamping num to den keeps an over-unity ratio at one ce per cycle
    assign num_eff = num > den ? den : num;
    assign sum = {1'b0, acc} + {1'b0, num_eff};
    assign wrap = den != '0 && sum >= {1'b0, den};
    assign hit = cfg_wr && cfg_ch == CH_W'(i);
    // shadow is taken on a wrap, on resync, or immediately when the channel is idle
    assign apply = pend && (resync || (!pause && (wrap || den == '0)));
    assign ce[i] = ce_r;
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
        num  <= ACC_W'(RST_NUM);
        den  <= ACC_W'(RST_DEN);
        snum <= ACC_W'(RST_NUM);
        sden <= ACC_W'(RST_DEN);
        acc  <= '0;
        pend <= 1'b0;
        ce_r <= 1'b0;
      end else begin
        if (hit) begin
          snum <= cfg_num;
          sden <= cfg_den;
        end
        // a write on the applying edge re-arms pend for the next wrap
        pend <= hit || (pend && !apply);
        if (apply) begin
          num <= snum;
          den <= sden;
        end
        acc  <= (resync || apply) ? '0 : pause ? acc : wrap ? ACC_W'(sum - {1'b0, den}) : sum[ACC_W-1:0];
        ce_r <= !resync && !pause && wrap;
      end
`ifdef CE_GEN_NEG_EN
    logic [ACC_W-1:0] half;
    logic cross, cen_r;
    assign half = den >> 1;
    // crossing the half point only counts when this edge does not also wrap
    assign cross = acc < half && sum >= {1'b0, half} && sum < {1'b0, den};
    assign ce_n[i] = cen_r;
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) cen_r <= 1'b0;
      else cen_r <= !resync && !pause && cross;
`endif
  end
endmodule
